// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-port responder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR   = 32'hBFC00000;
  localparam int          WORD_W         = 32;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/mem_byteen_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module mem_byteen_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IDX_W-1:0]          index,
  input  logic [BYTES_PER_WORD-1:0] we,
  input  logic [WORD_W-1:0]         wdata,
  input  logic                      rd,
  input  logic                      clr,
  output logic [WORD_W-1:0]         rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane writes; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (we[i]) begin
        mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register holds until the next completing read or error clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (rd) begin
      rdata <= mem[index];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Avalon-MM-style memory slave with fixed wait states and byte-lane writes.
// Define MEM_RAND_STALL_EN to add 0-3 LFSR-driven extra wait cycles per transfer.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          LATENCY     = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        resp_err
);

  localparam int             IDX_W     = $clog2(DEPTH_WORDS);
  localparam int             CNT_W     = $clog2(LATENCY + 4) + 1;
  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic               wr_q;
  logic               err_q;

  logic [31:0]        offset;
  logic               req;
  logic               cap_err;
  logic [CNT_W-1:0]   extra;
  logic [CNT_W-1:0]   load_cnt;
  logic               fire;
  logic [IDX_W-1:0]   cur_idx;
  logic [3:0]         cur_be;
  logic [31:0]        cur_wdata;
  logic               cur_wr;
  logic               cur_err;
  logic [3:0]         ram_we;
  logic               ram_rd;
  logic               ram_clr;

  assign offset  = address - BASE_ADDR;
  assign req     = read | write;
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  assign cap_err = (offset[1:0] != 2'b00) || (offset[31:IDX_W+2] != '0) || (read && write);

`ifdef MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11, free-running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
  assign extra = '0;
`endif

  assign load_cnt = LOAD_BASE + extra;

  // Select live inputs at capture, registered ones while waiting; decide access.
  always_comb begin
    cur_idx   = idx_q;
    cur_be    = be_q;
    cur_wdata = wdata_q;
    cur_wr    = wr_q;
    cur_err   = err_q;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        cur_idx   = offset[IDX_W+1:2];
        cur_be    = byteenable;
        cur_wdata = writedata;
        cur_wr    = write;
        cur_err   = cap_err;
        fire      = req && (load_cnt == '0);
      end
      WAIT:    fire = (cnt == CNT_W'(1));
      default: fire = 1'b0;
    endcase
    if (!reset) begin
      fire = 1'b0;
    end else begin
      fire = fire;
    end
    ram_we  = (fire && cur_wr && !cur_err) ? cur_be : 4'b0000;
    ram_rd  = fire && !cur_wr && !cur_err;
    ram_clr = fire && cur_err;
  end

  // Transfer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      waitrequest <= 1'b1;
      resp_err    <= 1'b0;
    end else begin
      waitrequest <= !fire;
      resp_err    <= fire && cur_err;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= offset[IDX_W+1:2];
            be_q    <= byteenable;
            wdata_q <= writedata;
            wr_q    <= write;
            err_q   <= cap_err;
            cnt     <= load_cnt;
            state   <= fire ? ACK : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt   <= cnt - CNT_W'(1);
          state <= fire ? ACK : WAIT;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_byteen_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .index (cur_idx),
    .we    (ram_we),
    .wdata (cur_wdata),
    .rd    (ram_rd),
    .clr   (ram_clr),
    .rdata (readdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expectations, monitor checks ACKs.
module tb_mem_responder;

`ifdef MEM_RAND_STALL_EN
  localparam int WMIN = 2;
  localparam int WMAX = 5;
`else
  localparam int WMIN = 2;
  localparam int WMAX = 2;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = 32'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = 4'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        resp_err;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          acks = 0;
  int          wcnt = 0;
  logic        busy = 1'b0;
  logic        prev_ack = 1'b0;
  logic        idle_chk = 1'b0;
  logic [31:0] idle_exp_rd = 32'h0;
  logic        timeout_hit = 1'b0;
  logic        timeout_seen = 1'b0;
  logic        end_chk = 1'b0;
  logic [31:0] model [16];

  mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  // Monitor: all comparisons happen here on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (idle_chk) begin
      n_vec++;
      if (waitrequest !== 1'b1 || resp_err !== 1'b0 || readdata !== idle_exp_rd) begin
        n_miss++;
        $display("FAIL idle_state: got wr=%b err=%b rd=%h, want wr=1 err=0 rd=%h",
                 waitrequest, resp_err, readdata, idle_exp_rd);
      end
    end
    if (timeout_hit && !timeout_seen) begin
      n_vec++;
      n_miss++;
      timeout_seen = 1'b1;
      $display("FAIL ack_timeout: got no ACK, want ACK within budget");
    end
    if (end_chk) begin
      n_vec++;
      if (sbq.size() != 0) begin
        n_miss++;
        $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
      end
    end
    if (reset) begin
      if (prev_ack) begin
        n_vec++;
        if (waitrequest !== 1'b1) begin
          n_miss++;
          $display("FAIL ack_width: got wr=%b after ACK, want 1", waitrequest);
        end
      end
      prev_ack = (waitrequest === 1'b0);
      if (busy && waitrequest === 1'b1) wcnt++;
      if (waitrequest === 1'b0) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_ack: got ACK, want none");
        end else begin
          e = sbq.pop_front();
          if (resp_err !== e.err) begin
            n_miss++;
            $display("FAIL resp_err: got %b, want %b", resp_err, e.err);
          end
          if (e.chk) begin
            n_vec++;
            if (readdata !== e.data) begin
              n_miss++;
              $display("FAIL readdata: got %h, want %h", readdata, e.data);
            end
          end
          n_vec++;
          if (wcnt < WMIN || wcnt > WMAX) begin
            n_miss++;
            $display("FAIL wait_count: got %0d, want %0d..%0d", wcnt, WMIN, WMAX);
          end
        end
        wcnt = 0;
        acks++;
      end
    end else begin
      wcnt = 0;
      prev_ack = 1'b0;
    end
  end

  task automatic wait_acks(input int target);
    for (int i = 0; i < 200 && acks < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (acks < target) timeout_hit = 1'b1;
  endtask

  task automatic xfer(input logic [31:0] a, input logic r, input logic w,
                      input logic [3:0] b, input logic [31:0] d,
                      input logic e_err, input logic e_chk, input logic [31:0] e_data);
    int target;
    sbq.push_back('{data: e_data, err: e_err, chk: e_chk});
    target = acks + 1;
    @(posedge clk);
    #1;
    address = a; read = r; write = w; byteenable = b; writedata = d; busy = 1'b1;
    wait_acks(target);
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0; busy = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    xfer(a, 1'b0, 1'b1, b, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e_data);
    xfer(a, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, e_data);
  endtask

  task automatic check_idle(input logic [31:0] e_rd);
    idle_exp_rd = e_rd;
    idle_chk = 1'b1;
    @(negedge clk);
    #1;
    idle_chk = 1'b0;
  endtask

  initial begin
    int target;
    logic [31:0] nv;
    logic [3:0]  b;
    logic [31:0] d;
    int          idx;

    repeat (3) @(posedge clk);
    check_idle(32'h0);
    #1 reset = 1'b1;

    // Basic write then read-back.
    wr(32'hBFC00004, 4'b1111, 32'hDEADBEEF);
    rd(32'hBFC00004, 32'hDEADBEEF);

    // Single-lane merge.
    wr(32'hBFC00008, 4'b1111, 32'h11223344);
    wr(32'hBFC00008, 4'b0010, 32'h0000AA00);
    rd(32'hBFC00008, 32'h1122AA44);

    // Error cases.
    wr(32'hBFC00000, 4'b1111, 32'h01234567);
    xfer(32'hBFC00002, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    xfer(32'h00000000, 1'b0, 1'b1, 4'hF, 32'h5, 1'b1, 1'b1, 32'h0);
    rd(32'hBFC00000, 32'h01234567);
    xfer(32'hBFC01000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    xfer(32'hBFC00004, 1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    rd(32'hBFC00004, 32'hDEADBEEF);

    // Last word in range and an all-lanes-off write.
    wr(32'hBFC00FFC, 4'b1111, 32'hA5A5A5A5);
    wr(32'hBFC00FFC, 4'b0000, 32'h12345678);
    rd(32'hBFC00FFC, 32'hA5A5A5A5);

    // Reset during WAIT discards the pending write.
    wr(32'hBFC00010, 4'b1111, 32'h0BADC0DE);
    @(posedge clk);
    #1;
    address = 32'hBFC00010; write = 1'b1; byteenable = 4'hF; writedata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0;
    @(posedge clk);
    check_idle(32'h0);
    reset = 1'b1;
    rd(32'hBFC00010, 32'h0BADC0DE);

    // Read held high: one ACK every LATENCY+1 cycles.
    repeat (3) sbq.push_back('{data: 32'hDEADBEEF, err: 1'b0, chk: 1'b1});
    target = acks + 3;
    @(posedge clk);
    #1;
    address = 32'hBFC00004; read = 1'b1; busy = 1'b1;
    wait_acks(target);
    @(posedge clk);
    #1;
    read = 1'b0; busy = 1'b0;

    // Scoreboard-modelled mixed traffic on the first 16 words.
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      wr(32'hBFC00000 + 32'(4 * i), 4'hF, model[i]);
    end
    for (int n = 0; n < 100; n++) begin
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        rd(32'hBFC00000 + 32'(4 * idx), model[idx]);
      end else begin
        b  = 4'($urandom_range(0, 15));
        d  = $urandom;
        nv = model[idx];
        for (int l = 0; l < 4; l++) if (b[l]) nv[8*l +: 8] = d[8*l +: 8];
        model[idx] = nv;
        wr(32'hBFC00000 + 32'(4 * idx), b, d);
      end
    end

    end_chk = 1'b1;
    @(negedge clk);
    #1;
    end_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
